// File: rtl/riot_timer_ctrl.sv
// Bus-side control for the 6532 interval timer: register decode, timer load strobes,
// timer/PA7 interrupt flags and enables, IRQ_N generation and read-data mux.
module riot_timer_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic       ACC,
    input  logic       R_W,
    input  logic [4:0] A,
    input  logic [7:0] DIN,
    input  logic       PA7,
    input  logic [7:0] TIM_OUT,
    output logic       TIM_WE,
    output logic [1:0] TIM_MODE,
    output logic [7:0] TIM_IN,
    output logic [7:0] DOUT,
    output logic       HIT,
    output logic       IRQ_N
);

    logic dec, wr_tim, wr_edge, rd_tim, rd_flg;
    logic zero_det, pa7_s, pa7_edge;

    logic                   tflag_q, tflag_d;
    logic                   pflag_q, pflag_d;
    logic                   tie_q, tie_d;
    logic                   pie_q, pie_d;
    logic                   epos_q, epos_d;
    logic                   arm_q, arm_d;
    logic                   pa7_d_q;
    logic                   irq_q, irq_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             dout_mux;

    assign dec     = ACC & A[2];
    assign wr_tim  = dec & ~R_W & A[4];
    assign wr_edge = dec & ~R_W & ~A[4];
    assign rd_tim  = dec & R_W & ~A[0];
    assign rd_flg  = dec & R_W & A[0];

    assign TIM_WE   = wr_tim;
    assign TIM_MODE = A[1:0];
    assign TIM_IN   = DIN;
    assign HIT      = rd_tim | rd_flg;

    // TIM_OUT still shows the pre-load count during the load cycle, so ignore it then
    assign zero_det = arm_q & ~wr_tim & (TIM_OUT == 8'h00);

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], PA7};
    assign pa7_s    = sync_q[SYNC_STAGES-1];
    assign pa7_edge = epos_q ? (pa7_s & ~pa7_d_q) : (~pa7_s & pa7_d_q);

    always_comb begin
        tflag_d = tflag_q;
        arm_d   = arm_q;
        tie_d   = tie_q;
        pie_d   = pie_q;
        epos_d  = epos_q;
        pflag_d = pflag_q;

        // Load beats zero detect; zero detect beats a read clear
        if (wr_tim) begin
            tflag_d = 1'b0;
            arm_d   = 1'b1;
        end else if (zero_det) begin
            tflag_d = 1'b1;
            arm_d   = 1'b0;
        end else if (rd_tim) begin
            tflag_d = 1'b0;
        end

        if (wr_tim | rd_tim) tie_d = A[3];

        if (wr_edge) begin
            epos_d = A[0];
            pie_d  = A[1];
        end

        if (pa7_edge)    pflag_d = 1'b1;
        else if (rd_flg) pflag_d = 1'b0;

        irq_d = (tflag_d & tie_d) | (pflag_d & pie_d);
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            tflag_q <= 1'b0;
            pflag_q <= 1'b0;
            tie_q   <= 1'b0;
            pie_q   <= 1'b0;
            epos_q  <= 1'b0;
            arm_q   <= 1'b0;
            pa7_d_q <= 1'b0;
            irq_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            tflag_q <= tflag_d;
            pflag_q <= pflag_d;
            tie_q   <= tie_d;
            pie_q   <= pie_d;
            epos_q  <= epos_d;
            arm_q   <= arm_d;
            pa7_d_q <= pa7_s;
            irq_q   <= irq_d;
            sync_q  <= sync_d;
        end
    end

    // IRQ_N comes straight off a flop so it cannot glitch
    assign IRQ_N = ~irq_q;

    always_comb begin
        dout_mux = 8'h00;
        if (rd_tim)      dout_mux = TIM_OUT;
        else if (rd_flg) dout_mux = {tflag_q, pflag_q, 6'b0};
    end

    assign DOUT = RES_N ? dout_mux : 8'h00;

endmodule

// File: tb/tb_riot_timer_ctrl.sv
// Self-checking bench for riot_timer_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the flag/enable rules.
module tb_riot_timer_ctrl;

    localparam int SYNC = 2;

    logic       CLK = 1'b0;
    logic       RES_N, ACC, R_W, PA7;
    logic [4:0] A;
    logic [7:0] DIN, TIM_OUT;
    logic       TIM_WE, HIT, IRQ_N;
    logic [1:0] TIM_MODE;
    logic [7:0] TIM_IN, DOUT;

    int vecs = 0;
    int errs = 0;

    // behavioural model state
    logic m_tflag, m_pflag, m_tie, m_pie, m_epos, m_arm;
    logic pq[$];   // PA7 pin samples, newest first

    riot_timer_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .RES_N(RES_N), .ACC(ACC), .R_W(R_W), .A(A), .DIN(DIN),
        .PA7(PA7), .TIM_OUT(TIM_OUT), .TIM_WE(TIM_WE), .TIM_MODE(TIM_MODE),
        .TIM_IN(TIM_IN), .DOUT(DOUT), .HIT(HIT), .IRQ_N(IRQ_N)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        m_tflag = 0; m_pflag = 0; m_tie = 0; m_pie = 0; m_epos = 0; m_arm = 0;
        pq.delete();
        for (int i = 0; i <= SYNC; i++) pq.push_back(1'b0);
    endfunction

    function automatic logic [7:0] exp_dout();
        if (!(ACC && A[2] && R_W)) return 8'h00;
        return A[0] ? {m_tflag, m_pflag, 6'b0} : TIM_OUT;
    endfunction

    function automatic logic exp_hit();
        return ACC & A[2] & R_W;
    endfunction

    function automatic logic exp_we();
        return ACC & A[2] & ~R_W & A[4];
    endfunction

    function automatic logic exp_irq();
        return ~((m_tflag & m_tie) | (m_pflag & m_pie));
    endfunction

    task automatic drive(input logic acc, input logic rw, input logic [4:0] a, input logic [7:0] din);
        ACC = acc; R_W = rw; A = a; DIN = din;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 5'd0, 8'd0);
    endtask

    // advance one clock, updating the model from the spec rules
    task automatic tick();
        logic dec, wt, we, rt, rf, zero, s, d, edg;
        logic n_tflag, n_arm, n_tie, n_pie, n_epos, n_pflag;
        dec  = ACC & A[2];
        wt   = dec & ~R_W & A[4];
        we   = dec & ~R_W & ~A[4];
        rt   = dec & R_W & ~A[0];
        rf   = dec & R_W & A[0];
        zero = m_arm && !wt && (TIM_OUT == 8'h00);
        s    = pq[SYNC-1];
        d    = pq[SYNC];
        edg  = m_epos ? (s & ~d) : (~s & d);
        n_tflag = wt ? 1'b0 : zero ? 1'b1 : rt ? 1'b0 : m_tflag;
        n_arm   = wt ? 1'b1 : zero ? 1'b0 : m_arm;
        n_tie   = (wt || rt) ? A[3] : m_tie;
        n_pie   = we ? A[1] : m_pie;
        n_epos  = we ? A[0] : m_epos;
        n_pflag = edg ? 1'b1 : rf ? 1'b0 : m_pflag;
        pq.push_front(PA7);
        void'(pq.pop_back());
        @(posedge CLK);
        m_tflag = n_tflag; m_arm = n_arm; m_tie = n_tie;
        m_pie = n_pie; m_epos = n_epos; m_pflag = n_pflag;
        #1;
    endtask

    task automatic test_reset();
        RES_N = 1'b0; PA7 = 1'b0; TIM_OUT = 8'h00;
        idle();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL reset_irq_n got=%b exp=1", IRQ_N); end
        vecs++; if (DOUT !== 8'h00) begin errs++; $display("FAIL reset_dout got=%h exp=00", DOUT); end
        vecs++; if (HIT !== 1'b0 || TIM_WE !== 1'b0) begin errs++; $display("FAIL reset_hit_we got=%b%b exp=00", HIT, TIM_WE); end
        @(negedge CLK);
        RES_N = 1'b1;
    endtask

    task automatic test_timer_irq();
        TIM_OUT = 8'h05;
        drive(1'b1, 1'b0, 5'b11101, 8'h02);
        #1;
        vecs++; if (TIM_WE !== 1'b1) begin errs++; $display("FAIL load_we got=%b exp=1", TIM_WE); end
        vecs++; if (TIM_MODE !== 2'b01 || TIM_IN !== 8'h02) begin errs++; $display("FAIL load_mode_in got=%b/%h exp=01/02", TIM_MODE, TIM_IN); end
        tick();
        idle(); TIM_OUT = 8'h02;
        #1;
        vecs++; if (TIM_WE !== 1'b0) begin errs++; $display("FAIL load_we_single got=%b exp=0", TIM_WE); end
        tick();
        TIM_OUT = 8'h01;
        tick();
        TIM_OUT = 8'h00;
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL irq_early got=%b exp=1", IRQ_N); end
        tick();
        vecs++; if (IRQ_N !== 1'b0) begin errs++; $display("FAIL timer_irq got=%b exp=0", IRQ_N); end
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h80 || HIT !== 1'b1) begin errs++; $display("FAIL flag_read_tflag got=%h/%b exp=80/1", DOUT, HIT); end
        tick();
    endtask

    task automatic test_timer_read();
        drive(1'b1, 1'b1, 5'b00100, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h00 || HIT !== 1'b1) begin errs++; $display("FAIL timer_read got=%h/%b exp=00/1", DOUT, HIT); end
        tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL read_clear_irq got=%b exp=1", IRQ_N); end
        idle();
        repeat (3) tick();
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h00) begin errs++; $display("FAIL no_rearm got=%h exp=00", DOUT); end
        tick();
        TIM_OUT = 8'hA5;
        drive(1'b1, 1'b1, 5'b00100, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'hA5) begin errs++; $display("FAIL timer_read_val got=%h exp=a5", DOUT); end
        tick();
        TIM_OUT = 8'h00;
    endtask

    task automatic test_load_zero();
        TIM_OUT = 8'h07;
        drive(1'b1, 1'b0, 5'b11101, 8'h00);
        tick();
        idle(); TIM_OUT = 8'h00;
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL load0_early got=%b exp=1", IRQ_N); end
        tick();
        vecs++; if (IRQ_N !== 1'b0) begin errs++; $display("FAIL load0_set got=%b exp=0", IRQ_N); end
        drive(1'b1, 1'b1, 5'b01100, 8'h00);
        tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL load0_clear got=%b exp=1", IRQ_N); end
        TIM_OUT = 8'h09;
        drive(1'b1, 1'b0, 5'b11101, 8'h09);
        tick();
        TIM_OUT = 8'h00;
        drive(1'b1, 1'b0, 5'b11101, 8'h03);
        tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL write_beats_zero got=%b exp=1", IRQ_N); end
        idle();
        tick();
        vecs++; if (IRQ_N !== 1'b0) begin errs++; $display("FAIL write_keeps_arm got=%b exp=0", IRQ_N); end
        drive(1'b1, 1'b1, 5'b01100, 8'h00);
        tick();
        TIM_OUT = 8'h04;
        drive(1'b1, 1'b0, 5'b11101, 8'h04);
        tick();
        TIM_OUT = 8'h00;
        drive(1'b1, 1'b1, 5'b01100, 8'h00);
        tick();
        vecs++; if (IRQ_N !== 1'b0) begin errs++; $display("FAIL set_beats_read got=%b exp=0", IRQ_N); end
        drive(1'b1, 1'b1, 5'b00100, 8'h00);
        tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL tie_clear got=%b exp=1", IRQ_N); end
    endtask

    task automatic test_pa7_edge();
        drive(1'b1, 1'b0, 5'b00111, 8'h00);
        tick();
        idle(); PA7 = 1'b1;
        tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL pa7_lat1 got=%b exp=1", IRQ_N); end
        tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL pa7_lat2 got=%b exp=1", IRQ_N); end
        tick();
        vecs++; if (IRQ_N !== 1'b0) begin errs++; $display("FAIL pa7_lat3 got=%b exp=0", IRQ_N); end
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h40) begin errs++; $display("FAIL pflag_read got=%h exp=40", DOUT); end
        tick();
        #1;
        vecs++; if (DOUT !== 8'h00) begin errs++; $display("FAIL pflag_cleared got=%h exp=00", DOUT); end
        tick();
        idle(); PA7 = 1'b0;
        repeat (4) tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL pa7_fall_irq got=%b exp=1", IRQ_N); end
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h00) begin errs++; $display("FAIL pa7_fall_flag got=%h exp=00", DOUT); end
        tick();
    endtask

    task automatic test_edge_collision();
        idle(); PA7 = 1'b1;
        tick();
        tick();
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        tick();
        idle();
        #1;
        vecs++; if (IRQ_N !== 1'b0) begin errs++; $display("FAIL collide_irq got=%b exp=0", IRQ_N); end
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h40) begin errs++; $display("FAIL collide_flag got=%h exp=40", DOUT); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'(($urandom % 4) != 0), 1'($urandom), 5'($urandom), 8'($urandom));
            TIM_OUT = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
            if (($urandom % 5) == 0) PA7 = ~PA7;
            #1;
            vecs++; if (DOUT !== exp_dout()) begin errs++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", i, DOUT, exp_dout()); end
            vecs++; if (HIT !== exp_hit() || TIM_WE !== exp_we()) begin errs++; $display("FAIL rnd_hit_we cyc=%0d got=%b%b exp=%b%b", i, HIT, TIM_WE, exp_hit(), exp_we()); end
            tick();
            vecs++; if (IRQ_N !== exp_irq()) begin errs++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, IRQ_N, exp_irq()); end
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 5'b00111, 8'h00);
        tick();
        idle(); PA7 = 1'b0;
        repeat (4) tick();
        PA7 = 1'b1;
        repeat (4) tick();
        TIM_OUT = 8'h05;
        drive(1'b1, 1'b0, 5'b11101, 8'h00);
        tick();
        idle(); TIM_OUT = 8'h00;
        tick();
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'hC0 || IRQ_N !== 1'b0) begin errs++; $display("FAIL pre_reset got=%h/%b exp=c0/0", DOUT, IRQ_N); end
        #2 RES_N = 1'b0;
        model_reset();
        #1;
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL async_rst_irq got=%b exp=1", IRQ_N); end
        vecs++; if (DOUT !== 8'h00) begin errs++; $display("FAIL async_rst_dout got=%h exp=00", DOUT); end
        @(negedge CLK);
        RES_N = 1'b1;
        idle();
        repeat (4) tick();
        vecs++; if (IRQ_N !== 1'b1) begin errs++; $display("FAIL post_rst_irq got=%b exp=1", IRQ_N); end
        drive(1'b1, 1'b1, 5'b00101, 8'h00);
        #1;
        vecs++; if (DOUT !== 8'h00) begin errs++; $display("FAIL post_rst_flags got=%h exp=00", DOUT); end
        tick();
    endtask

    initial begin
        test_reset();
        test_timer_irq();
        test_timer_read();
        test_load_zero();
        test_pa7_edge();
        test_edge_collision();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/riot_timer_ctrl.md
Name: riot_timer_ctrl

Overview:
- Bus-side control stage for the 6532 interval timer, sitting directly upstream of it.
- Decodes CPU accesses to the timer and interrupt registers, and drives the timer's write-enable, mode and load value.
- Maintains the timer and PA7 edge-detect interrupt flags and enables, and produces IRQ_N.
- Muxes timer count and interrupt-flag read data onto the read bus.

Parameters:
SYNC_STAGES, 2, flops in the PA7 input synchronizer (minimum 2)

Ports:
CLK      input   1  system clock
RES_N    input   1  reset; asynchronous, active-low
ACC      input   1  one-cycle access strobe; already qualified by chip select and RS_N=1 (I/O space)
R_W      input   1  1 = read, 0 = write
A        input   5  register address A[4:0]
DIN      input   8  write data from CPU
PA7      input   1  asynchronous port A bit 7 pin
TIM_OUT  input   8  current count from the interval timer
TIM_WE   output  1  timer load strobe (combinational decode)
TIM_MODE output  2  timer prescale select, equal to A[1:0]
TIM_IN   output  8  timer load value, equal to DIN
DOUT     output  8  read data (combinational)
HIT      output  1  1 when this block owns DOUT for the current access
IRQ_N    output  1  interrupt request, active-low

Behaviour:
- Decode is active only when ACC=1 and A[2]=1. All other accesses give HIT=0 and no state change.
- Write timer (R_W=0, A[4]=1):
  - TIM_WE=1 in the same cycle.
  - TIE <= A[3].
  - Clear TFLAG and set ARM at the clock edge.
- Write edge control (R_W=0, A[4]=0):
  - EDGE_POS <= A[0] (1 = rising, 0 = falling).
  - PIE <= A[1].
- Read timer (R_W=1, A[0]=0):
  - DOUT = TIM_OUT and HIT=1.
  - At the clock edge: TIE <= A[3], clear TFLAG.
- Read flags (R_W=1, A[0]=1):
  - DOUT = {TFLAG, PFLAG, 6'b0} and HIT=1.
  - Clear PFLAG at the clock edge. TFLAG is unaffected.
- Outside decoded reads: DOUT=8'h00.
- TIM_MODE and TIM_IN are driven continuously. They are meaningful only while TIM_WE=1.
- Timer zero detect:
  - In any cycle with ARM=1, TIM_WE=0 and TIM_OUT==8'h00: TFLAG <= 1 and ARM <= 0.
  - This yields exactly one flag set per load, including after a load of 0.
  - Detection is suppressed in the TIM_WE cycle because TIM_OUT still shows the old value.
- Timer flag priorities:
  - Timer write wins over a simultaneous zero detect: TFLAG=0, ARM=1.
  - Timer read clears TFLAG in the same edge a zero detect would set it: the set wins.
- PA7 path:
  - PA7 passes through the SYNC_STAGES synchronizer and then into a registered delay PA7_D.
  - PFLAG is set on an edge of the synchronized signal in the selected direction.
  - Latency from the pin edge to PFLAG=1 is SYNC_STAGES+1 clocks.
  - A set coinciding with a flag-register read clear: the set wins.
  - Changing EDGE_POS does not itself set PFLAG; the next edge uses the new polarity.
- IRQ_N = ~((TFLAG & TIE) | (PFLAG & PIE)), decoded from registers and glitch-free.
- Reset (asynchronous assert, any time, including mid-access):
  - TFLAG, PFLAG, TIE, PIE, EDGE_POS, ARM = 0.
  - Synchronizer and PA7_D = 0.
  - Resulting outputs: IRQ_N=1, TIM_WE=0 unless ACC decodes, DOUT=0.
  - The first PA7 edge after reset is judged from the 0 reset state.
- No other state. Flags stay set indefinitely until cleared or reset.

Test Plan:
- Reset, then write timer A=5'b11101 (mode 01, TIE=1), DIN=8'h02 with TIM_OUT modelled counting 02→01→00 -> TIM_WE pulses once with TIM_MODE=01 and TIM_IN=02; TFLAG=1 and IRQ_N=0 the cycle after TIM_OUT=00; a read at A=5'b00101 returns 8'h80.
- Same setup, then read timer at A=5'b00100 (A3=0) -> DOUT=TIM_OUT; TFLAG clears, TIE clears, IRQ_N=1; TIM_OUT remaining 00 does not re-set TFLAG (ARM=0).
- Timer write of DIN=8'h00 -> TFLAG sets exactly one cycle after TIM_WE; a timer write in the same cycle as a zero detect -> TFLAG=0, ARM=1.
- Write edge control A=5'b00111 (rising, PIE=1), drive PA7 0→1 -> PFLAG=1 and IRQ_N=0 after 3 clocks; PA7 1→0 sets nothing; flag read returns 8'h40 and the following read returns 8'h00.
- PA7 edge arriving in the same cycle as a flag read -> PFLAG remains 1.
- Assert RES_N low mid-read with both flags set -> IRQ_N=1, DOUT=00 and all flags/enables 0 immediately, without a clock.
